// File: rtl/lock_controller.sv
// ---------------------------------------------------------------------------
// lock_controller
//
// Six-digit BCD combination lock with a bounded number of consecutive failed
// attempts, a timed lockout, and in-field reprogramming of the code while the
// lock is open. Every output is driven straight from a flop, so each one
// reflects the inputs sampled on the previous rising edge.
//
// Ports
//   clock        in   single clock; all state changes on its rising edge
//   reset        in   synchronous, active-high; overrides every other input
//   digit_in     in   [3:0] entered digit, 0..9 legal, 10..15 treated as wrong
//   digit_valid  in   one-cycle strobe qualifying digit_in
//   relock       in   level; returns OPEN or FAIL to IDLE
//   prog_mode    in   level; in OPEN, a strobed digit starts code programming
//   unlocked     out  high while the lock is OPEN
//   locked_out   out  high while the lock is in LOCKOUT
//   fail_count   out  [2:0] consecutive failed attempts (never above MAX_FAILS)
//   digit_idx    out  [2:0] digits taken in the current entry/programming run
//   disp_digit   out  [3:0] last digit taken from digit_in
//   disp_mode    out  [2:0] 0 DIGIT, 1 OPEN, 2 CLOSED, 3 ERR, 4 LOCKED, 5 PROG
//   prog_err     out  one-cycle pulse when programming is aborted
// ---------------------------------------------------------------------------
module lock_controller #(
    parameter logic [23:0] DEFAULT_CODE   = 24'h211525,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       relock,
    input  logic       prog_mode,
    output logic       unlocked,
    output logic       locked_out,
    output logic [2:0] fail_count,
    output logic [2:0] digit_idx,
    output logic [3:0] disp_digit,
    output logic [2:0] disp_mode,
    output logic       prog_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER   = 3'd1,
        S_OPEN    = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_PROG    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        DM_DIGIT  = 3'd0,
        DM_OPEN   = 3'd1,
        DM_CLOSED = 3'd2,
        DM_ERR    = 3'd3,
        DM_LOCKED = 3'd4,
        DM_PROG   = 3'd5
    } disp_e;

    localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAILS);
    localparam logic [15:0] LOCK_LOAD  = 16'(LOCKOUT_CYCLES);
    localparam logic [2:0]  LAST_IDX   = 3'd5;

    // Digit 0 is the most significant nibble of a code word.
    function automatic logic [3:0] code_digit(input logic [23:0] code, input logic [2:0] idx);
        case (idx)
            3'd0:    code_digit = code[23:20];
            3'd1:    code_digit = code[19:16];
            3'd2:    code_digit = code[15:12];
            3'd3:    code_digit = code[11:8];
            3'd4:    code_digit = code[7:4];
            default: code_digit = code[3:0];
        endcase
    endfunction

    function automatic logic [23:0] put_digit(input logic [23:0] code, input logic [2:0] idx,
                                              input logic [3:0] d);
        put_digit = code;
        case (idx)
            3'd0:    put_digit[23:20] = d;
            3'd1:    put_digit[19:16] = d;
            3'd2:    put_digit[15:12] = d;
            3'd3:    put_digit[11:8]  = d;
            3'd4:    put_digit[7:4]   = d;
            default: put_digit[3:0]   = d;
        endcase
    endfunction

    state_e      state_q,      state_d;
    logic [23:0] code_q,       code_d;
    logic [23:0] shadow_q,     shadow_d;
    logic        mismatch_q,   mismatch_d;
    logic [2:0]  fail_count_q, fail_count_d;
    logic [2:0]  digit_idx_q,  digit_idx_d;
    logic [3:0]  disp_digit_q, disp_digit_d;
    disp_e       disp_mode_q,  disp_mode_d;
    logic        prog_err_q,   prog_err_d;
    logic        unlocked_q,   unlocked_d;
    logic        locked_q,     locked_d;
    logic [15:0] lock_cnt_q,   lock_cnt_d;

    logic       bad_digit;
    logic       digit_miss;
    logic [2:0] fail_next;

    // An out-of-range digit always counts as wrong, whatever the code holds.
    assign bad_digit  = (digit_in > 4'd9);
    assign digit_miss = bad_digit || (digit_in != code_digit(code_q, digit_idx_q));
    assign fail_next  = fail_count_q + 3'd1;

    // NOTE: every signal assigned in this block gets its default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        shadow_d     = shadow_q;
        mismatch_d   = mismatch_q;
        fail_count_d = fail_count_q;
        digit_idx_d  = digit_idx_q;
        disp_digit_d = disp_digit_q;
        disp_mode_d  = disp_mode_q;
        prog_err_d   = 1'b0;
        lock_cnt_d   = lock_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Any strobe starts an attempt, even an illegal digit, so every
                // attempt is exactly six digits long.
                if (digit_valid) begin
                    state_d      = S_ENTER;
                    digit_idx_d  = 3'd1;
                    mismatch_d   = digit_miss;
                    disp_digit_d = digit_in;
                    disp_mode_d  = bad_digit ? DM_ERR : DM_DIGIT;
                end
            end

            S_ENTER: begin
                if (digit_valid) begin
                    disp_digit_d = digit_in;
                    if (digit_idx_q == LAST_IDX) begin
                        digit_idx_d = 3'd0;
                        if (!(mismatch_q || digit_miss)) begin
                            state_d      = S_OPEN;
                            fail_count_d = 3'd0;
                            disp_mode_d  = DM_OPEN;
                        end else begin
                            fail_count_d = fail_next;
                            if (fail_next == FAIL_LIMIT) begin
                                state_d     = S_LOCKOUT;
                                lock_cnt_d  = LOCK_LOAD;
                                disp_mode_d = DM_LOCKED;
                            end else begin
                                state_d     = S_FAIL;
                                disp_mode_d = DM_CLOSED;
                            end
                        end
                    end else begin
                        digit_idx_d = digit_idx_q + 3'd1;
                        mismatch_d  = mismatch_q || digit_miss;
                        disp_mode_d = bad_digit ? DM_ERR : DM_DIGIT;
                    end
                end
            end

            S_OPEN: begin
                if (relock) begin
                    state_d     = S_IDLE;
                    disp_mode_d = DM_DIGIT;
                end else if (prog_mode && digit_valid) begin
                    disp_digit_d = digit_in;
                    if (bad_digit) begin
                        // An illegal first digit aborts programming on the spot.
                        prog_err_d = 1'b1;
                    end else begin
                        state_d     = S_PROG;
                        digit_idx_d = 3'd1;
                        shadow_d    = put_digit(24'h0, 3'd0, digit_in);
                        disp_mode_d = DM_PROG;
                    end
                end
            end

            S_FAIL: begin
                if (relock) begin
                    state_d     = S_IDLE;
                    disp_mode_d = DM_DIGIT;
                end
            end

            S_LOCKOUT: begin
                // The counter holds LOCKOUT_CYCLES on the entry edge, so leaving
                // when it would reach zero gives exactly LOCKOUT_CYCLES cycles.
                lock_cnt_d = lock_cnt_q - 16'd1;
                if (lock_cnt_q <= 16'd1) begin
                    state_d      = S_IDLE;
                    lock_cnt_d   = 16'd0;
                    fail_count_d = 3'd0;
                    disp_mode_d  = DM_DIGIT;
                end
            end

            S_PROG: begin
                if (digit_valid) begin
                    disp_digit_d = digit_in;
                    if (bad_digit) begin
                        state_d     = S_OPEN;
                        digit_idx_d = 3'd0;
                        prog_err_d  = 1'b1;
                        disp_mode_d = DM_OPEN;
                    end else if (digit_idx_q == LAST_IDX) begin
                        // The live code only changes once all six digits are in.
                        code_d      = put_digit(shadow_q, digit_idx_q, digit_in);
                        state_d     = S_IDLE;
                        digit_idx_d = 3'd0;
                        disp_mode_d = DM_DIGIT;
                    end else begin
                        shadow_d    = put_digit(shadow_q, digit_idx_q, digit_in);
                        digit_idx_d = digit_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        unlocked_d = (state_d == S_OPEN);
        locked_d   = (state_d == S_LOCKOUT);
    end

    // NOTE: state uses non-blocking assignments so every flop samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the code word is a register, not a RAM, and must come back
            // to DEFAULT_CODE on reset; the shadow is cleared too so no partial
            // programming survives.
            state_q      <= S_IDLE;
            code_q       <= DEFAULT_CODE;
            shadow_q     <= 24'h0;
            mismatch_q   <= 1'b0;
            fail_count_q <= 3'd0;
            digit_idx_q  <= 3'd0;
            disp_digit_q <= 4'd0;
            disp_mode_q  <= DM_DIGIT;
            prog_err_q   <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_q     <= 1'b0;
            lock_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            shadow_q     <= shadow_d;
            mismatch_q   <= mismatch_d;
            fail_count_q <= fail_count_d;
            digit_idx_q  <= digit_idx_d;
            disp_digit_q <= disp_digit_d;
            disp_mode_q  <= disp_mode_d;
            prog_err_q   <= prog_err_d;
            unlocked_q   <= unlocked_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign unlocked   = unlocked_q;
    assign locked_out = locked_q;
    assign fail_count = fail_count_q;
    assign digit_idx  = digit_idx_q;
    assign disp_digit = disp_digit_q;
    assign disp_mode  = disp_mode_q;
    assign prog_err   = prog_err_q;

endmodule

// File: tb/tb_lock_controller.sv
// ---------------------------------------------------------------------------
// tb_lock_controller
//
// Directed stimulus for lock_controller. The stimulus process pushes the
// hand-computed output snapshot expected after each edge into a scoreboard
// queue, tagged with the cycle it belongs to; an independent monitor pops and
// compares on the falling edge of that cycle.
// Snapshot packing: {unlocked, locked_out, fail_count, digit_idx,
//                    disp_digit, disp_mode, prog_err}
// ---------------------------------------------------------------------------
module tb_lock_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       relock = 1'b0;
    logic       prog_mode = 1'b0;
    logic       unlocked;
    logic       locked_out;
    logic [2:0] fail_count;
    logic [2:0] digit_idx;
    logic [3:0] disp_digit;
    logic [2:0] disp_mode;
    logic       prog_err;

    lock_controller #(
        .DEFAULT_CODE   (24'h211525),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .relock      (relock),
        .prog_mode   (prog_mode),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .fail_count  (fail_count),
        .digit_idx   (digit_idx),
        .disp_digit  (disp_digit),
        .disp_mode   (disp_mode),
        .prog_err    (prog_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        string       nm;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [15:0] pk(input int u, input int lo, input int fc, input int idx,
                                       input int dd, input int dm, input int pe);
        pk = {u[0], lo[0], fc[2:0], idx[2:0], dd[3:0], dm[2:0], pe[0]};
    endfunction

    // Monitor: compares whatever expectation is due this cycle.
    always @(negedge clock) begin
        logic [15:0] act;
        exp_t        e;
        act = {unlocked, locked_out, fail_count, digit_idx, disp_digit, disp_mode, prog_err};
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc < cyc_cnt) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d was never sampled (now %0d)",
                         e.nm, e.cyc, cyc_cnt);
            end else if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s @%0d: got u=%0b lo=%0b fc=%0d idx=%0d dd=%0d dm=%0d pe=%0b, need u=%0b lo=%0b fc=%0d idx=%0d dd=%0d dm=%0d pe=%0b",
                         e.nm, cyc_cnt,
                         act[15], act[14], act[13:11], act[10:8], act[7:4], act[3:1], act[0],
                         e.v[15], e.v[14], e.v[13:11], e.v[10:8], e.v[7:4], e.v[3:1], e.v[0]);
            end
        end
    end

    // Drive one cycle of inputs and register what must appear after that edge.
    task automatic step(input bit v, input int d, input bit rl, input bit pm, input bit rs,
                        input string nm, input logic [15:0] e);
        exp_t x;
        digit_valid = v;
        digit_in    = 4'(d);
        relock      = rl;
        prog_mode   = pm;
        reset       = rs;
        x.cyc = cyc_cnt + 1;
        x.nm  = nm;
        x.v   = e;
        sb.push_back(x);
        @(posedge clock);
        #1;
        digit_valid = 1'b0;
        relock      = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic dig(input int d, input bit pm, input string nm, input logic [15:0] e);
        step(1'b1, d, 1'b0, pm, 1'b0, nm, e);
    endtask

    task automatic nop(input string nm, input logic [15:0] e);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, nm, e);
    endtask

    task automatic rel(input string nm, input logic [15:0] e);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, nm, e);
    endtask

    // First five digits of an attempt: index climbs 1..5, fail_count unchanged.
    task automatic enter5(input int s[6], input int fc, input string nm);
        for (int i = 0; i < 5; i++)
            dig(s[i], 1'b0, nm, pk(0, 0, fc, i + 1, s[i], 0, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_dflt[6]  = '{2, 1, 1, 5, 2, 5};
        int c_wrong[6] = '{2, 1, 0, 0, 2, 0};
        int c_nines[6] = '{9, 9, 9, 9, 9, 9};
        int c_new[6]   = '{9, 8, 7, 6, 5, 4};
        int c_zero[6]  = '{0, 0, 0, 0, 0, 0};

        // Reset wins over a simultaneous strobe.
        step(1'b1, 7, 1'b0, 1'b0, 1'b1, "reset", pk(0, 0, 0, 0, 0, 0, 0));

        // Default code opens.
        enter5(c_dflt, 0, "enter_ok");
        dig(5, 1'b0, "open", pk(1, 0, 0, 0, 5, 1, 0));
        nop("open_hold", pk(1, 0, 0, 0, 5, 1, 0));
        dig(3, 1'b0, "open_ignore_digit", pk(1, 0, 0, 0, 5, 1, 0));
        // Relock beats a programming strobe in the same cycle.
        step(1'b1, 3, 1'b1, 1'b1, 1'b0, "relock_wins", pk(0, 0, 0, 0, 5, 0, 0));

        // Wrong code -> FAIL; strobes ignored; relock keeps fail_count.
        enter5(c_wrong, 0, "enter_wrong");
        dig(0, 1'b0, "fail1", pk(0, 0, 1, 0, 0, 2, 0));
        dig(4, 1'b0, "fail_ignore_digit", pk(0, 0, 1, 0, 0, 2, 0));
        rel("fail_relock", pk(0, 0, 1, 0, 0, 0, 0));

        // Illegal digit in the middle shows ERR, attempt still runs six digits.
        dig(2, 1'b0, "err_d1", pk(0, 0, 1, 1, 2, 0, 0));
        dig(12, 1'b0, "err_shown", pk(0, 0, 1, 2, 12, 3, 0));
        dig(1, 1'b0, "err_d3", pk(0, 0, 1, 3, 1, 0, 0));
        dig(5, 1'b0, "err_d4", pk(0, 0, 1, 4, 5, 0, 0));
        dig(2, 1'b0, "err_d5", pk(0, 0, 1, 5, 2, 0, 0));
        dig(5, 1'b0, "fail2", pk(0, 0, 2, 0, 5, 2, 0));
        rel("fail2_relock", pk(0, 0, 2, 0, 5, 0, 0));

        // Third consecutive failure -> LOCKOUT for exactly 8 cycles.
        enter5(c_nines, 2, "enter_nines");
        dig(9, 1'b0, "lockout_entry", pk(0, 1, 3, 0, 9, 4, 0));
        for (int i = 1; i <= 7; i++)
            step(1'(i % 2), 2, (i == 3), 1'b0, 1'b0, "lockout_hold", pk(0, 1, 3, 0, 9, 4, 0));
        nop("lockout_exit", pk(0, 0, 0, 0, 9, 0, 0));

        // Program 987654 from OPEN.
        enter5(c_dflt, 0, "enter_ok2");
        dig(5, 1'b0, "open2", pk(1, 0, 0, 0, 5, 1, 0));
        for (int i = 0; i < 5; i++)
            dig(c_new[i], 1'b1, "prog_digit", pk(0, 0, 0, i + 1, c_new[i], 5, 0));
        dig(4, 1'b1, "prog_done", pk(0, 0, 0, 0, 4, 0, 0));
        prog_mode = 1'b0;

        // Old code now fails, new code opens.
        enter5(c_dflt, 0, "enter_old");
        dig(5, 1'b0, "old_code_fails", pk(0, 0, 1, 0, 5, 2, 0));
        rel("old_relock", pk(0, 0, 1, 0, 5, 0, 0));
        enter5(c_new, 1, "enter_new");
        dig(4, 1'b0, "new_code_opens", pk(1, 0, 0, 0, 4, 1, 0));

        // Aborted programming: prog_err pulse, back to OPEN, code unchanged.
        dig(1, 1'b1, "abort_p1", pk(0, 0, 0, 1, 1, 5, 0));
        dig(2, 1'b1, "abort_p2", pk(0, 0, 0, 2, 2, 5, 0));
        dig(3, 1'b1, "abort_p3", pk(0, 0, 0, 3, 3, 5, 0));
        dig(13, 1'b1, "prog_err_pulse", pk(1, 0, 0, 0, 13, 1, 1));
        prog_mode = 1'b0;
        nop("prog_err_clears", pk(1, 0, 0, 0, 13, 1, 0));
        rel("abort_relock", pk(0, 0, 0, 0, 13, 0, 0));
        enter5(c_new, 0, "enter_new2");
        dig(4, 1'b0, "code_kept", pk(1, 0, 0, 0, 4, 1, 0));
        rel("kept_relock", pk(0, 0, 0, 0, 4, 0, 0));

        // Drive into LOCKOUT again, then reset mid-lockout.
        for (int k = 0; k < 3; k++) begin
            enter5(c_zero, k, "enter_zero");
            if (k < 2) begin
                dig(0, 1'b0, "zero_fail", pk(0, 0, k + 1, 0, 0, 2, 0));
                rel("zero_relock", pk(0, 0, k + 1, 0, 0, 0, 0));
            end else begin
                dig(0, 1'b0, "zero_lockout", pk(0, 1, 3, 0, 0, 4, 0));
            end
        end
        nop("lockout2_hold", pk(0, 1, 3, 0, 0, 4, 0));
        step(1'b1, 9, 1'b1, 1'b1, 1'b1, "reset_in_lockout", pk(0, 0, 0, 0, 0, 0, 0));

        // Reset restored the default code.
        enter5(c_dflt, 0, "enter_after_reset");
        dig(5, 1'b0, "default_restored", pk(1, 0, 0, 0, 5, 1, 0));

        // Let the monitor drain anything still due.
        repeat (2) @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter DEFAULT_CODE, 24'h211525, six BCD digits (MS digit first) loaded at reset.
REQ-002 Parameter MAX_FAILS, 3, consecutive failed attempts before lockout (legal 1..7).
REQ-003 Parameter LOCKOUT_CYCLES, 1000, lockout duration in clock cycles (legal 1..2^16-1).
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 digit_in  in  4  entered digit; legal 0..9, 10..15 invalid.
REQ-007 digit_valid  in  1  one-cycle strobe; digit_in sampled when high.
REQ-008 relock  in  1  level; returns OPEN/FAIL to IDLE.
REQ-009 prog_mode  in  1  level; in OPEN, a strobed digit starts code programming.
REQ-010 unlocked  out  1  high while state is OPEN.
REQ-011 locked_out  out  1  high while state is LOCKOUT.
REQ-012 fail_count  out  3  consecutive failed attempts.
REQ-013 digit_idx  out  3  digits accepted in current ENTER/PROG sequence (0..6).
REQ-014 disp_digit  out  4  last accepted digit_in.
REQ-015 disp_mode  out  3  0 DIGIT, 1 OPEN, 2 CLOSED, 3 ERR, 4 LOCKED, 5 PROG.
REQ-016 prog_err  out  1  one-cycle pulse on aborted programming.

Function
REQ-017 States SHALL be IDLE, ENTER, OPEN, FAIL, LOCKOUT, PROG; all outputs registered, valid the cycle after the sampling edge.
REQ-018 IDLE: digit_valid -> ENTER, digit_idx=1, mismatch flag set if digit_in != code MS digit or digit_in>9.
REQ-019 ENTER: each digit_valid increments digit_idx and ORs (digit_in != code digit[digit_idx] or digit_in>9) into mismatch; disp_mode=ERR for a >9 digit, else DIGIT.
REQ-020 ENTER on 6th digit: mismatch=0 -> OPEN, fail_count=0; else fail_count+1, -> LOCKOUT if new fail_count==MAX_FAILS, else FAIL; digit_idx=0.
REQ-021 OPEN: relock -> IDLE; prog_mode&digit_valid -> PROG, digit_idx=1, digit stored in shadow; relock wins over simultaneous digit_valid.
REQ-022 FAIL: disp_mode=CLOSED; relock -> IDLE; digit_valid ignored.
REQ-023 LOCKOUT: counter loaded with LOCKOUT_CYCLES on entry, decrements each cycle; at 0 -> IDLE, fail_count=0; digit_valid and relock ignored.
REQ-024 PROG: digits fill shadow register; digit>9 -> OPEN, prog_err pulse, code unchanged; 6th legal digit -> code register replaced atomically, -> IDLE.
REQ-025 digit_valid in IDLE with digit>9 SHALL still enter ENTER with mismatch set (no early reject; attempt length always 6).
REQ-026 Successful OPEN SHALL clear fail_count; FAIL->IDLE SHALL preserve it.
REQ-027 fail_count SHALL never exceed MAX_FAILS.

Reset
REQ-028 reset SHALL override all inputs in its cycle: state IDLE, code=DEFAULT_CODE, fail_count=0, digit_idx=0, disp_digit=0, disp_mode=DIGIT, unlocked=0, locked_out=0, prog_err=0, lockout counter=0.
REQ-029 reset mid-ENTER, mid-PROG or mid-LOCKOUT SHALL discard partial sequence and shadow register; a programmed code SHALL revert to DEFAULT_CODE.

Verification
REQ-030 Digits 2,1,1,5,2,5 after reset -> unlocked=1, disp_mode=1, fail_count=0 one cycle after 6th strobe.
REQ-031 Digits 2,1,0,0,2,0 -> FAIL, disp_mode=2, fail_count=1; relock -> IDLE, fail_count stays 1.
REQ-032 Three wrong sequences (LOCKOUT_CYCLES=8) -> locked_out=1 for exactly 8 cycles, strobes ignored, then IDLE, fail_count=0.
REQ-033 Digit 12 at index 2 -> disp_mode=3 that cycle; sequence completes to FAIL after 6 strobes.
REQ-034 From OPEN with prog_mode=1 enter 9,8,7,6,5,4 -> IDLE; 211525 then fails; 987654 opens.
REQ-035 PROG with 4th digit 13 -> prog_err pulse, state OPEN, old code still opens; reset during LOCKOUT -> IDLE next cycle.
